moving_avg_filter: RTL and testbench
====================================

// Module: moving_avg_filter
// PURPOSE
//   Streaming boxcar (moving-average) filter over the last 2**LOG2_TAPS accepted samples.
//   It is the parametrised successor of the 8-bit lab filter: configurable sample width and
//   window depth, a valid qualifier, a synchronous flush, and a programmable threshold flag.
//   It sits between a sample source (ADC/test pattern) and downstream display/decision logic.
// PARAMETERS
//   DATA_W     8   unsigned sample width, in bits
//   LOG2_TAPS  2   log2 of the window depth; N = 2**LOG2_TAPS (range 1..6)
//   WAIT_FULL  1   1: out_valid is suppressed until N samples have been accepted;
//                  0: output from the first sample (empty slots count as 0)
// PORTS
//   CLOCK_50   in   1                   system clock; all logic is rising-edge triggered
//   rst        in   1                   synchronous reset, active-high
//   in_valid   in   1                   x is accepted on any rising edge where in_valid=1
//   x          in   DATA_W              unsigned input sample
//   clear      in   1                   synchronous flush of the window (same effect as rst)
//   threshold  in   DATA_W              compare level for y_flag; sampled each cycle
//   out_valid  out  1                   one-cycle pulse: y_avg/y_flag updated this cycle
//   y_avg      out  DATA_W              floor(sum of window / N)
//   y_flag     out  1                   1 when y_avg > threshold (strictly greater)
//   primed     out  1                   1 once N samples are accepted since reset/clear
// BEHAVIOUR
//   - Storage: circular buffer of N x DATA_W, write pointer wr_ptr (LOG2_TAPS bits),
//     running sum of DATA_W+LOG2_TAPS bits (cannot overflow), and fill counter 0..N (saturates).
//   - Accepted sample (in_valid=1, clear=0, rst=0), all in one edge:
//     buf[wr_ptr] <= x; sum <= sum + x - buf[wr_ptr];
//     wr_ptr <= wr_ptr+1 (wraps N-1 -> 0); fill <= min(fill+1, N).
//   - Latency: 1 cycle. The edge that accepts sample k also registers y_avg = new_sum >> LOG2_TAPS.
//     out_valid is high for exactly the following cycle.
//   - out_valid = 1 after an accepted sample only if (WAIT_FULL==0) or (new fill == N).
//   - y_avg and y_flag hold their values between accepted samples.
//   - y_flag is registered together with y_avg: (new_avg > threshold).
//     A threshold change takes effect at the next accepted sample only.
//   - primed = (fill == N), registered.
//   - No state machine beyond the fill counter:
//     FILLING (fill < N) -> RUNNING (fill == N); rst/clear returns it to FILLING.
//   - Reset and clear: every buffer entry, sum, wr_ptr and fill go to 0.
//     y_avg=0, y_flag=0, out_valid=0, primed=0 on the next edge.
//     rst mid-stream discards the window and produces no out_valid for the in-flight sample.
//   - clear=1 and in_valid=1 on the same edge: clear wins, and the sample is dropped.
//   - rst dominates clear and in_valid.
//   - in_valid gaps: nothing changes; the window is sample-based, not time-based.
// TESTING  (DATA_W=8, LOG2_TAPS=2, WAIT_FULL=1, threshold=16 unless noted)
//   1 Fill/latency: x=13,20,17,12 on 4 consecutive valid edges -> out_valid only in the
//     cycle after 12; y_avg=15 (62/4); y_flag=0; primed=1 from that cycle.
//   2 Slide/wrap: continue with 25,31 -> y_avg=18 (74/4) with y_flag=1, then y_avg=21 (85/4).
//     wr_ptr wraps with no glitch.
//   3 Max width: four samples of 255 -> sum=1020, y_avg=255, no overflow.
//     Then a single 0 -> y_avg=191 (765/4).
//   4 Gaps: valid 13, idle 5 cycles, 20, idle, 17, 12 -> same result as scenario 1.
//     out_valid never pulses in idle cycles.
//   5 Clear collision: after scenario 2, assert clear with in_valid=1 and x=200 ->
//     primed=0, y_avg=0, no out_valid. The next 4 samples of 8 -> y_avg=8, and 200 is absent.
//   6 Reset mid-fill, and WAIT_FULL=0: rst after 2 samples -> all outputs 0.
//     With WAIT_FULL=0, first x=40 -> out_valid=1, y_avg=10.

Source files
------------

// File: rtl/moving_avg_filter_if.sv
// Sample stream and result bus between a sample source and the moving-average filter.
// The source is the master; the filter is the slave and returns the averaged result.
interface moving_avg_filter_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] x;
  logic              clear;
  logic [DATA_W-1:0] threshold;
  logic              out_valid;
  logic [DATA_W-1:0] y_avg;
  logic              y_flag;
  logic              primed;

  modport master (
    output in_valid, x, clear, threshold,
    input  out_valid, y_avg, y_flag, primed
  );

  modport slave (
    input  in_valid, x, clear, threshold,
    output out_valid, y_avg, y_flag, primed
  );
endinterface

// File: rtl/moving_avg_filter.sv
// Streaming boxcar filter: floor of the mean of the last 2**LOG2_TAPS accepted samples,
// with a one-cycle result pulse, a strict-greater threshold flag and a window-full indicator.
module moving_avg_filter #(
  parameter int DATA_W    = 8,
  parameter int LOG2_TAPS = 2,
  parameter int WAIT_FULL = 1
) (
  input logic               CLOCK_50,
  input logic               rst,
  moving_avg_filter_if.slave bus
);
  localparam int N      = 1 << LOG2_TAPS;
  localparam int SUM_W  = DATA_W + LOG2_TAPS;
  localparam int FILL_W = LOG2_TAPS + 1;
  localparam logic [FILL_W-1:0] FULL = FILL_W'(N);

  logic [DATA_W-1:0]    win [N];
  logic [LOG2_TAPS-1:0] wr_ptr;
  logic [SUM_W-1:0]     sum;
  logic [FILL_W-1:0]    fill;

  logic [SUM_W-1:0]     sum_next;
  logic [FILL_W-1:0]    fill_upd;
  logic [DATA_W-1:0]    avg_next;

  // The slot being overwritten is always the oldest sample, so the running sum
  // stays exact without re-adding the whole window; modular wrap of the
  // intermediate sum + x cancels out once the old sample is subtracted.
  always_comb begin
    sum_next = sum + SUM_W'(bus.x) - SUM_W'(win[wr_ptr]);
    avg_next = DATA_W'(sum_next >> LOG2_TAPS);
    fill_upd = fill;
    if (bus.in_valid && (fill != FULL)) begin
      fill_upd = fill + FILL_W'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst || bus.clear) begin
      for (int i = 0; i < N; i++) begin
        win[i] <= '0;
      end
      sum           <= '0;
      wr_ptr        <= '0;
      fill          <= '0;
      bus.out_valid <= 1'b0;
      bus.y_avg     <= '0;
      bus.y_flag    <= 1'b0;
      bus.primed    <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      fill          <= fill_upd;
      bus.primed    <= (fill_upd == FULL);
      if (bus.in_valid) begin
        win[wr_ptr]   <= bus.x;
        sum           <= sum_next;
        wr_ptr        <= wr_ptr + LOG2_TAPS'(1);
        bus.y_avg     <= avg_next;
        bus.y_flag    <= (avg_next > bus.threshold);
        bus.out_valid <= (WAIT_FULL == 0) || (fill_upd == FULL);
      end
    end
  end
endmodule

// File: tb/tb_moving_avg_filter.sv
// Directed bench for moving_avg_filter: a WAIT_FULL=1 and a WAIT_FULL=0 instance share stimulus
// and are compared every cycle against a queue-based window model, plus hand-computed literals.
module tb_moving_avg_filter;
  localparam int DATA_W    = 8;
  localparam int LOG2_TAPS = 2;
  localparam int N         = 4;

  logic clk = 1'b0;
  logic rst;
  int   thr = 16;
  int   checks = 0;
  int   passed = 0;
  bit   check_en = 1'b0;

  always #5 clk = ~clk;

  moving_avg_filter_if #(.DATA_W(DATA_W)) bus_full ();
  moving_avg_filter_if #(.DATA_W(DATA_W)) bus_early ();

  moving_avg_filter #(.DATA_W(DATA_W), .LOG2_TAPS(LOG2_TAPS), .WAIT_FULL(1)) dut_full (
    .CLOCK_50(clk),
    .rst     (rst),
    .bus     (bus_full.slave)
  );

  moving_avg_filter #(.DATA_W(DATA_W), .LOG2_TAPS(LOG2_TAPS), .WAIT_FULL(0)) dut_early (
    .CLOCK_50(clk),
    .rst     (rst),
    .bus     (bus_early.slave)
  );

  // Reference: the window is literally the last N accepted samples, averaged by integer division.
  int window[$];
  int exp_avg = 0;
  bit exp_flag = 1'b0;
  bit exp_primed = 1'b0;
  bit exp_valid_full = 1'b0;
  bit exp_valid_early = 1'b0;

  always @(posedge clk) begin : model
    int total;
    if (rst || bus_full.clear) begin
      window.delete();
      exp_avg         = 0;
      exp_flag        = 1'b0;
      exp_primed      = 1'b0;
      exp_valid_full  = 1'b0;
      exp_valid_early = 1'b0;
    end else begin
      exp_valid_full  = 1'b0;
      exp_valid_early = 1'b0;
      if (bus_full.in_valid) begin
        window.push_back(int'(bus_full.x));
        if (window.size() > N) void'(window.pop_front());
        total = 0;
        foreach (window[i]) total += window[i];
        exp_avg         = total / N;
        exp_flag        = exp_avg > int'(bus_full.threshold);
        exp_primed      = (window.size() == N);
        exp_valid_full  = exp_primed;
        exp_valid_early = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end else begin
      passed++;
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("full.out_valid", 32'(bus_full.out_valid), 32'(exp_valid_full));
      checkOutput("full.y_avg", 32'(bus_full.y_avg), 32'(exp_avg));
      checkOutput("full.y_flag", 32'(bus_full.y_flag), 32'(exp_flag));
      checkOutput("full.primed", 32'(bus_full.primed), 32'(exp_primed));
      checkOutput("early.out_valid", 32'(bus_early.out_valid), 32'(exp_valid_early));
      checkOutput("early.y_avg", 32'(bus_early.y_avg), 32'(exp_avg));
      checkOutput("early.y_flag", 32'(bus_early.y_flag), 32'(exp_flag));
      checkOutput("early.primed", 32'(bus_early.primed), 32'(exp_primed));
    end
  end

  task automatic applyStimulus(input bit v, input int xv, input bit clr, input bit r);
    @(posedge clk);
    #1;
    rst                 = r;
    bus_full.in_valid   = v;
    bus_full.x          = DATA_W'(xv);
    bus_full.clear      = clr;
    bus_full.threshold  = DATA_W'(thr);
    bus_early.in_valid  = v;
    bus_early.x         = DATA_W'(xv);
    bus_early.clear     = clr;
    bus_early.threshold = DATA_W'(thr);
  endtask

  task automatic sample(input int xv);
    applyStimulus(1'b1, xv, 1'b0, 1'b0);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    rst                 = 1'b1;
    bus_full.in_valid   = 1'b0;
    bus_full.x          = '0;
    bus_full.clear      = 1'b0;
    bus_full.threshold  = DATA_W'(thr);
    bus_early.in_valid  = 1'b0;
    bus_early.x         = '0;
    bus_early.clear     = 1'b0;
    bus_early.threshold = DATA_W'(thr);
    @(posedge clk);
    #1;
    check_en = 1'b1;
    checkOutput("reset y_avg", 32'(bus_full.y_avg), 0);
    checkOutput("reset out_valid", 32'(bus_full.out_valid), 0);
    checkOutput("reset primed", 32'(bus_full.primed), 0);
    applyStimulus(1'b0, 0, 1'b0, 1'b1);
    idle();

    $display("[TB] fill and latency");
    sample(13); sample(20); sample(17); sample(12);
    idle();
    checkOutput("s1 out_valid", 32'(bus_full.out_valid), 1);
    checkOutput("s1 y_avg", 32'(bus_full.y_avg), 15);
    checkOutput("s1 y_flag", 32'(bus_full.y_flag), 0);
    checkOutput("s1 primed", 32'(bus_full.primed), 1);
    idle();
    checkOutput("s1 pulse ends", 32'(bus_full.out_valid), 0);
    checkOutput("s1 y_avg holds", 32'(bus_full.y_avg), 15);

    $display("[TB] slide and wrap");
    sample(25);
    sample(31);
    checkOutput("s2 y_avg 74/4", 32'(bus_full.y_avg), 18);
    checkOutput("s2 y_flag", 32'(bus_full.y_flag), 1);
    idle();
    checkOutput("s2 y_avg 85/4", 32'(bus_full.y_avg), 21);

    $display("[TB] clear collision");
    applyStimulus(1'b1, 200, 1'b1, 1'b0);
    idle();
    checkOutput("s5 primed", 32'(bus_full.primed), 0);
    checkOutput("s5 y_avg", 32'(bus_full.y_avg), 0);
    checkOutput("s5 out_valid", 32'(bus_full.out_valid), 0);
    sample(8); sample(8); sample(8); sample(8);
    idle();
    checkOutput("s5 y_avg eights", 32'(bus_full.y_avg), 8);
    checkOutput("s5 out_valid", 32'(bus_full.out_valid), 1);

    $display("[TB] max width");
    sample(255); sample(255); sample(255); sample(255);
    idle();
    checkOutput("s3 y_avg 1020/4", 32'(bus_full.y_avg), 255);
    sample(0);
    idle();
    checkOutput("s3 y_avg 765/4", 32'(bus_full.y_avg), 191);

    $display("[TB] gaps");
    applyStimulus(1'b0, 0, 1'b1, 1'b0);
    sample(13);
    repeat (5) idle();
    sample(20);
    idle();
    sample(17);
    sample(12);
    idle();
    checkOutput("s4 y_avg", 32'(bus_full.y_avg), 15);
    checkOutput("s4 out_valid", 32'(bus_full.out_valid), 1);

    $display("[TB] reset mid-fill and early output");
    sample(50);
    sample(60);
    applyStimulus(1'b1, 99, 1'b1, 1'b1);
    idle();
    checkOutput("s6 full y_avg", 32'(bus_full.y_avg), 0);
    checkOutput("s6 early y_avg", 32'(bus_early.y_avg), 0);
    checkOutput("s6 early out_valid", 32'(bus_early.out_valid), 0);
    sample(40);
    idle();
    checkOutput("s6 early out_valid", 32'(bus_early.out_valid), 1);
    checkOutput("s6 early y_avg", 32'(bus_early.y_avg), 10);
    checkOutput("s6 full out_valid", 32'(bus_full.out_valid), 0);
    thr = 5;
    idle();
    checkOutput("s6 flag waits", 32'(bus_early.y_flag), 0);
    sample(0);
    idle();
    checkOutput("s6 flag after sample", 32'(bus_early.y_flag), 1);
    repeat (2) idle();

    check_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
